// File: rtl/ysyx_24110015_scoreboard_pkg.sv
// Shared scoreboard types for the NPC pipeline.
// Register address width, default in-flight bound, count type.
package ysyx_24110015_pkg;
    localparam int REG_ADDR_W       = 5;
    localparam int NR_REGS_DEF      = 32;
    localparam int MAX_INFLIGHT_DEF = 4;
    localparam int CW =
        $clog2(MAX_INFLIGHT_DEF + 1);

    typedef logic [CW-1:0]         sb_cnt_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/ysyx_24110015_scoreboard_if.sv
// Issue/retire handshake bundle between IDU, EXU, WBU
// and the register-write scoreboard.
interface ysyx_24110015_scoreboard_if
    import ysyx_24110015_pkg::*;
#(
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) ();
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    logic          idu_valid;
    logic          idu_ready;
    logic          idu_reg1_read;
    logic          idu_reg2_read;
    reg_addr_t     idu_raddr1;
    reg_addr_t     idu_raddr2;
    logic          idu_RegWrite;
    reg_addr_t     idu_waddr;
    logic          rs1_forward;
    logic          rs2_forward;
    logic          exu_ready;
    logic          issue_fire;
    logic          wbu_valid;
    logic          wbu_RegWrite;
    reg_addr_t     wbu_waddr;
    logic          flush;
    logic          rs1_busy;
    logic          rs2_busy;
    logic [IW-1:0] inflight_cnt;
    logic          sb_error;

    modport slave (
        input  idu_valid,
        input  idu_reg1_read,
        input  idu_reg2_read,
        input  idu_raddr1,
        input  idu_raddr2,
        input  idu_RegWrite,
        input  idu_waddr,
        input  rs1_forward,
        input  rs2_forward,
        input  exu_ready,
        input  wbu_valid,
        input  wbu_RegWrite,
        input  wbu_waddr,
        input  flush,
        output idu_ready,
        output issue_fire,
        output rs1_busy,
        output rs2_busy,
        output inflight_cnt,
        output sb_error
    );

    modport master (
        output idu_valid,
        output idu_reg1_read,
        output idu_reg2_read,
        output idu_raddr1,
        output idu_raddr2,
        output idu_RegWrite,
        output idu_waddr,
        output rs1_forward,
        output rs2_forward,
        output exu_ready,
        output wbu_valid,
        output wbu_RegWrite,
        output wbu_waddr,
        output flush,
        input  idu_ready,
        input  issue_fire,
        input  rs1_busy,
        input  rs2_busy,
        input  inflight_cnt,
        input  sb_error
    );
endinterface

// File: rtl/ysyx_24110015_sb_counter.sv
// Saturating up/down counter with synchronous clear.
// err pulses when a step would leave [0, MAX].
module ysyx_24110015_sb_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         err
);
    logic [W-1:0] count_nxt;
    logic         at_max;
    logic         at_zero;

    assign at_max  = (count == W'(MAX));
    assign at_zero = (count == '0);

    // a paired inc/dec cancels and never flags
    always_comb begin
        count_nxt = count;
        err       = 1'b0;
        unique case (1'b1)
            clr: begin
                count_nxt = '0;
            end
            (~clr & inc & ~dec): begin
                if (at_max) err = 1'b1;
                else count_nxt = count + W'(1);
            end
            (~clr & dec & ~inc): begin
                if (at_zero) err = 1'b1;
                else count_nxt = count - W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else          count <= count_nxt;
    end
endmodule

// File: rtl/ysyx_24110015_scoreboard.sv
// Register-write scoreboard: per-register pending writers,
// in-flight bound and the IDU->EXU issue handshake.
module ysyx_24110015_scoreboard
    import ysyx_24110015_pkg::*;
#(
    parameter int NR_REGS      = NR_REGS_DEF,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
    input  logic clock,
    input  logic reset_n,
    ysyx_24110015_scoreboard_if.slave sb
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    logic [IW-1:0]      reg_cnt [NR_REGS];
    logic [NR_REGS-1:0] inc_vec;
    logic [NR_REGS-1:0] dec_vec;
    logic [NR_REGS-1:0] err_vec;
    logic [IW-1:0]      inf_cnt;
    logic               inf_err;
    logic               rs1_busy;
    logic               rs2_busy;
    logic               ready;
    logic               fire;
    logic               retire;
    logic               sb_error;

    assign reg_cnt[0] = '0;
    assign inc_vec[0] = 1'b0;
    assign dec_vec[0] = 1'b0;
    assign err_vec[0] = 1'b0;

    // x0 has no counter; x1..x(NR_REGS-1) each get one
    for (genvar r = 1; r < NR_REGS; r++) begin : g_reg
        assign inc_vec[r] = fire & sb.idu_RegWrite &
            (sb.idu_waddr == REG_ADDR_W'(r));
        assign dec_vec[r] = retire & sb.wbu_RegWrite &
            (sb.wbu_waddr == REG_ADDR_W'(r));

        ysyx_24110015_sb_counter #(
            .MAX (MAX_INFLIGHT),
            .W   (IW)
        ) u_cnt (
            .clock   (clock),
            .reset_n (reset_n),
            .inc     (inc_vec[r]),
            .dec     (dec_vec[r]),
            .clr     (sb.flush),
            .count   (reg_cnt[r]),
            .err     (err_vec[r])
        );
    end

    ysyx_24110015_sb_counter #(
        .MAX (MAX_INFLIGHT),
        .W   (IW)
    ) u_inflight (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (fire),
        .dec     (retire),
        .clr     (sb.flush),
        .count   (inf_cnt),
        .err     (inf_err)
    );

    assign rs1_busy = sb.idu_reg1_read &
        (sb.idu_raddr1 != '0) &
        (reg_cnt[sb.idu_raddr1] != '0);
    assign rs2_busy = sb.idu_reg2_read &
        (sb.idu_raddr2 != '0) &
        (reg_cnt[sb.idu_raddr2] != '0);

    // a busy source only stalls when it cannot be forwarded
    assign ready = sb.exu_ready & ~sb.flush &
        (inf_cnt < IW'(MAX_INFLIGHT)) &
        ~(rs1_busy & ~sb.rs1_forward) &
        ~(rs2_busy & ~sb.rs2_forward);

    assign fire   = sb.idu_valid & ready;
    assign retire = sb.wbu_valid & ~sb.flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sb_error <= 1'b0;
        else if (inf_err | (|err_vec)) sb_error <= 1'b1;
    end

    assign sb.idu_ready    = ready;
    assign sb.issue_fire   = fire;
    assign sb.rs1_busy     = rs1_busy;
    assign sb.rs2_busy     = rs2_busy;
    assign sb.inflight_cnt = inf_cnt;
    assign sb.sb_error     = sb_error;
endmodule

// File: doc/ysyx_24110015_scoreboard.md
# ysyx_24110015_scoreboard

Register-write scoreboard for the in-order NPC pipeline. It tracks in-flight destination registers, counted when instructions issue from IDU and uncounted when they retire in WBU. It combines per-register busy status with the forward checker's `rs1_forward`/`rs2_forward` to decide whether IDU may issue. It also bounds total in-flight instructions and owns the issue handshake between IDU and EXU.

## Interface
Parameters:
- `NR_REGS`, 32: architectural registers tracked; x0 never tracked.
- `MAX_INFLIGHT`, 4: maximum issued-but-unretired instructions.

Ports:
- `clock`  in  1: single clock; all state on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `idu_valid`  in  1: IDU holds a decoded instruction.
- `idu_ready`  out  1: scoreboard allows issue; combinational.
- `idu_reg1_read`, `idu_reg2_read`  in  1 each: instruction reads rs1/rs2.
- `idu_raddr1`, `idu_raddr2`  in  5 each: source register numbers.
- `idu_RegWrite`  in  1: instruction writes rd.
- `idu_waddr`  in  5: rd.
- `rs1_forward`, `rs2_forward`  in  1 each: forward checker can supply the operand this cycle.
- `exu_ready`  in  1: EXU accepts an instruction.
- `issue_fire`  out  1: `idu_valid & idu_ready`.
- `wbu_valid`  in  1: one instruction retires this cycle.
- `wbu_RegWrite`  in  1: retiring instruction wrote a register.
- `wbu_waddr`  in  5: retiring rd.
- `flush`  in  1: synchronous pipeline flush.
- `rs1_busy`, `rs2_busy`  out  1 each: source has a pending write.
- `inflight_cnt`  out  $clog2(MAX_INFLIGHT+1): instructions in flight.
- `sb_error`  out  1: sticky protocol-violation flag.

## Operation
- **Per-register state.** Register r holds `cnt[r]`, width CW = $clog2(MAX_INFLIGHT+1). It is the number of in-flight writers of r.
- **Busy.** `rsN_busy = idu_regN_read & (idu_raddrN != 0) & (cnt[idu_raddrN] != 0)`. It uses registered counts only. A same-cycle WBU retire is not subtracted; the forward checker covers that case.
- **Ready.** `idu_ready = exu_ready & ~flush & (inflight_cnt < MAX_INFLIGHT) & ~(rs1_busy & ~rs1_forward) & ~(rs2_busy & ~rs2_forward)`.
- **Issue increments** (when `issue_fire`):
  - `inflight_cnt` always.
  - `cnt[idu_waddr]` if `idu_RegWrite` and `idu_waddr != 0`.
- **Retire decrements** (when `wbu_valid`):
  - `inflight_cnt` always.
  - `cnt[wbu_waddr]` if `wbu_RegWrite` and `wbu_waddr != 0`.
- **Simultaneous issue and retire.**
  - Same rd: `cnt` unchanged.
  - `inflight_cnt`: unchanged.
- **Underflow.** A retire while the count is 0 leaves the count at 0 and sets `sb_error`. This applies to either `cnt` or `inflight_cnt`.
- **Overflow.** An increment of a count already at MAX_INFLIGHT is impossible by construction, because the `inflight_cnt` gate prevents it. If it occurs anyway: the count holds and `sb_error` is set.
- **Flush.**
  - All `cnt[]` and `inflight_cnt` clear to 0 next edge.
  - Flush wins over a same-cycle issue and retire; both are dropped.
  - `sb_error` is not cleared by flush.
- **`sb_error`.** Cleared only by reset.
- **Reset (`reset_n` low).** Asynchronously clears all `cnt[]`, `inflight_cnt` and `sb_error` to 0. Immediately after reset:
  - `rsN_busy` = 0.
  - `idu_ready` = `exu_ready`.
  - `issue_fire` = `idu_valid & exu_ready`.
- **Reset mid-operation.** Discards all tracking; no outstanding retires are expected after reset.

## Timing
- Issue in cycle N: counts visible from cycle N+1, so `rsN_busy` can assert in N+1.
- Retire in cycle N: counts reduced from N+1.
- Outputs `idu_ready`, `issue_fire` and `rsN_busy` are combinational from inputs and registered counts, with no internal combinational loop. `rsN_forward` must not depend on `idu_ready`.
- Load-use stall duration is set by `rsN_forward` timing; the scoreboard adds no bubble beyond it.

## Structure
- Shared package `ysyx_24110015_pkg` holds:
  - `REG_ADDR_W = 5`.
  - The default `MAX_INFLIGHT`.
  - Typedef `sb_cnt_t` (logic [CW-1:0]).
- Sub-module `ysyx_24110015_sb_counter` is instantiated NR_REGS-1 times (x1..x31) plus once for `inflight_cnt`. It is a saturating up/down counter with:
  - inputs `inc`, `dec`, `clr`;
  - asynchronous active-low reset;
  - outputs `count` and `err` (underflow/overflow pulse).
- Top level: decode `idu_waddr`/`wbu_waddr` into one-hot inc/dec vectors, OR the `err` pulses into the sticky `sb_error`, and mux counts by `idu_raddrN`.

## Test plan
- **Reset then free issue.** `reset_n` low then high, `exu_ready=1`, `idu_valid=1`, no reads → `idu_ready=1` and `issue_fire=1` every cycle, up to `inflight_cnt=4`. `idu_ready` then drops to 0 with no retires.
- **RAW stall with no forward.** Issue with `idu_RegWrite=1`, `idu_waddr=5`; next cycle read x5 with `rs1_forward=0` → `rs1_busy=1`, `idu_ready=0`. Raise `rs1_forward=1` → `idu_ready=1`. `wbu_valid` with `wbu_waddr=5` → `cnt[5]=0` and `rs1_busy=0` next cycle.
- **x0 ignored.** Issue with `idu_waddr=0`, then read `idu_raddr1=0` → `rs1_busy=0`; `inflight_cnt` still increments.
- **Simultaneous issue and retire, same rd=7.** With `cnt[7]=1`, issue and retire rd=7 in one cycle → `cnt[7]` stays 1 and `inflight_cnt` is unchanged.
- **Flush with issue pending.** Three in flight plus `flush=1` together with `idu_valid=1` → `issue_fire=0`; next cycle `inflight_cnt=0` and all busy flags 0.
- **Underflow.** `wbu_valid=1`, `wbu_RegWrite=1`, `wbu_waddr=3` while `cnt[3]=0` → `cnt[3]` stays 0 and `sb_error=1`. `sb_error` holds through a flush and clears only on `reset_n` low.
